// File: rtl/sd_data_pkg.sv
// Shared types and defaults for the SD data-path controller.
// Holds the controller state encoding and the default counter widths.
package sd_data_pkg;

  localparam int DEFAULT_BLOCK_W   = 8;
  localparam int DEFAULT_TIMEOUT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SETUP      = 3'd1,
    ST_CHECK_FIFO = 3'd2,
    ST_TRANSFER   = 3'd3,
    ST_WAIT_DONE  = 3'd4,
    ST_DONE       = 3'd5
  } data_state_t;

endpackage

// File: rtl/sd_data_ctrl_if.sv
// Request/handshake bundle between a host (master) and the SD data controller (slave).
interface sd_data_ctrl_if import sd_data_pkg::*; #(
  parameter int BLOCK_W   = DEFAULT_BLOCK_W,
  parameter int TIMEOUT_W = DEFAULT_TIMEOUT_W
);

  logic                 NewData;
  logic                 WriteRead;
  logic [BLOCK_W-1:0]   Blocks;
  logic                 MultipleData;
  logic                 Timeout_enable;
  logic [TIMEOUT_W-1:0] Timeout_reg;
  logic                 FIFO_ok;
  logic                 Complete;

  logic                 Send;
  logic                 Idle;
  logic                 Fifo_rd;
  logic                 Fifo_wr;
  logic                 Data_transfer_complete;
  logic                 Timeout;
  logic [BLOCK_W-1:0]   Blocks_left;

  modport master (
    output NewData, WriteRead, Blocks, MultipleData,
           Timeout_enable, Timeout_reg, FIFO_ok, Complete,
    input  Send, Idle, Fifo_rd, Fifo_wr,
           Data_transfer_complete, Timeout, Blocks_left
  );

  modport slave (
    input  NewData, WriteRead, Blocks, MultipleData,
           Timeout_enable, Timeout_reg, FIFO_ok, Complete,
    output Send, Idle, Fifo_rd, Fifo_wr,
           Data_transfer_complete, Timeout, Blocks_left
  );

endinterface

// File: rtl/sd_timeout_cnt.sv
// Per-block timeout supervisor: counts enabled cycles since the last clear
// and flags when the count reaches a nonzero limit.
module sd_timeout_cnt import sd_data_pkg::*; #(
  parameter int TIMEOUT_W = DEFAULT_TIMEOUT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 hit
);

  logic [TIMEOUT_W-1:0] count;
  logic                 active;

  // A zero limit disables supervision entirely rather than matching at once.
  assign active = enable && (limit != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (active && (count != '1)) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign hit = active && (count == limit);

endmodule

// File: rtl/sd_data_ctrl.sv
// SD card data-phase controller: sequences FIFO checks, block sends and
// completions for single/multi-block reads and writes, with timeout abort.
module sd_data_ctrl import sd_data_pkg::*; #(
  parameter int BLOCK_W   = DEFAULT_BLOCK_W,
  parameter int TIMEOUT_W = DEFAULT_TIMEOUT_W
) (
  input  logic          clk,
  input  logic          rst,
  sd_data_ctrl_if.slave bus
);

  data_state_t        state;
  logic               armed;
  logic               write_q;
  logic               idle_q;
  logic               send_q;
  logic               fifo_rd_q;
  logic               fifo_wr_q;
  logic               done_q;
  logic               timeout_q;
  logic [BLOCK_W-1:0] blocks_left;

  logic               cnt_clear;
  logic               cnt_enable;
  logic               timeout_hit;

  assign cnt_clear  = (state == ST_TRANSFER);
  assign cnt_enable = (state == ST_WAIT_DONE) && bus.Timeout_enable;

  sd_timeout_cnt #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .limit  (bus.Timeout_reg),
    .hit    (timeout_hit)
  );

  // armed starts set so the first request after reset is taken immediately;
  // afterwards NewData must be seen low in IDLE before another start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      armed       <= 1'b1;
      write_q     <= 1'b0;
      idle_q      <= 1'b1;
      send_q      <= 1'b0;
      fifo_rd_q   <= 1'b0;
      fifo_wr_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      blocks_left <= '0;
    end else begin
      send_q    <= 1'b0;
      fifo_rd_q <= 1'b0;
      fifo_wr_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!bus.NewData) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed       <= 1'b0;
            idle_q      <= 1'b0;
            write_q     <= bus.WriteRead;
            blocks_left <= bus.MultipleData ? bus.Blocks : BLOCK_W'(1);
            state       <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          state <= (blocks_left == '0) ? ST_DONE : ST_CHECK_FIFO;
        end

        ST_CHECK_FIFO: begin
          if (bus.FIFO_ok) begin
            state <= ST_TRANSFER;
          end
        end

        ST_TRANSFER: begin
          send_q    <= 1'b1;
          fifo_rd_q <= write_q;
          state     <= ST_WAIT_DONE;
        end

        // Completion is checked first so a same-cycle timeout match loses.
        ST_WAIT_DONE: begin
          if (bus.Complete) begin
            blocks_left <= blocks_left - BLOCK_W'(1);
            fifo_wr_q   <= ~write_q;
            state       <= (blocks_left == BLOCK_W'(1)) ? ST_DONE : ST_CHECK_FIFO;
          end else if (timeout_hit) begin
            timeout_q   <= 1'b1;
            blocks_left <= '0;
            idle_q      <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        ST_DONE: begin
          done_q <= 1'b1;
          idle_q <= 1'b1;
          state  <= ST_IDLE;
        end

        default: begin
          idle_q <= 1'b1;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Send                   = send_q;
  assign bus.Idle                   = idle_q;
  assign bus.Fifo_rd                = fifo_rd_q;
  assign bus.Fifo_wr                = fifo_wr_q;
  assign bus.Data_transfer_complete = done_q;
  assign bus.Timeout                = timeout_q;
  assign bus.Blocks_left            = blocks_left;

endmodule

// File: tb/tb_sd_data_ctrl.sv
// Scoreboard bench for sd_data_ctrl: stimulus predicts timestamped output
// pulses from the transfer rules; a negedge monitor pops and compares them.
module tb_sd_data_ctrl;
  import sd_data_pkg::*;

  localparam int BW = DEFAULT_BLOCK_W;
  localparam int TW = DEFAULT_TIMEOUT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sd_data_ctrl_if #(.BLOCK_W(BW), .TIMEOUT_W(TW)) bus ();

  sd_data_ctrl #(.BLOCK_W(BW), .TIMEOUT_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum int {EV_SEND, EV_FIFO_RD, EV_FIFO_WR, EV_DONE, EV_TIMEOUT} ev_kind_t;
  typedef struct {
    int       at;
    ev_kind_t kind;
    int       blocks_left;
    bit       idle;
  } ev_t;

  ev_t expq[$];
  int  total = 0;
  int  bad   = 0;

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void pushExp(int at, ev_kind_t kind, int bl, bit idle);
    ev_t e;
    e.at = at; e.kind = kind; e.blocks_left = bl; e.idle = idle;
    expq.push_back(e);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  task automatic compareEvent(input ev_kind_t kind);
    ev_t e;
    total++;
    if (expq.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_pulse: got kind %0d at cycle %0d, required no pulse", kind, cyc);
    end else begin
      e = expq.pop_front();
      if (e.at != cyc || e.kind != kind || e.blocks_left != int'(bus.Blocks_left) || e.idle != bus.Idle) begin
        bad++;
        $display("[TB] FAIL pulse: got kind %0d cyc %0d left %0d idle %0b, required kind %0d cyc %0d left %0d idle %0b",
                 kind, cyc, bus.Blocks_left, bus.Idle, e.kind, e.at, e.blocks_left, e.idle);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.Send === 1'b1)                   compareEvent(EV_SEND);
    if (bus.Fifo_rd === 1'b1)                compareEvent(EV_FIFO_RD);
    if (bus.Fifo_wr === 1'b1)                compareEvent(EV_FIFO_WR);
    if (bus.Data_transfer_complete === 1'b1) compareEvent(EV_DONE);
    if (bus.Timeout === 1'b1)                compareEvent(EV_TIMEOUT);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_idle"},        32'(bus.Idle), 1);
    checkOutput({tag, "_blocks_left"}, 32'(bus.Blocks_left), 0);
    checkOutput({tag, "_send"},        32'(bus.Send), 0);
    checkOutput({tag, "_fifo_rd"},     32'(bus.Fifo_rd), 0);
    checkOutput({tag, "_fifo_wr"},     32'(bus.Fifo_wr), 0);
    checkOutput({tag, "_done"},        32'(bus.Data_transfer_complete), 0);
    checkOutput({tag, "_timeout"},     32'(bus.Timeout), 0);
  endtask

  // Called in cycle s with inputs free; the start request is sampled at the end of s.
  // df: cycles of FIFO_ok low per block (-1 random); dc: Complete delay after the
  // first wait cycle (-1 random, -2 never); abort_blk: block index to reset in.
  task automatic applyStimulus(input bit wr, input int blocks, input bit multi,
                               input bit ten, input int treg, input int df_fix,
                               input int dc_fix, input int abort_blk, input bit hold_nd);
    int n, s, t, w, df, dc;
    bit timed_out;
    s = cyc;
    timed_out = 1'b0;
    bus.NewData        = 1'b1;
    bus.WriteRead      = wr;
    bus.Blocks         = BW'(blocks);
    bus.MultipleData   = multi;
    bus.Timeout_enable = ten;
    bus.Timeout_reg    = TW'(treg);
    bus.FIFO_ok        = rbit();
    bus.Complete       = rbit();
    n = multi ? blocks : 1;
    step();
    bus.NewData      = rbit();
    bus.WriteRead    = rbit();
    bus.MultipleData = rbit();
    bus.Blocks       = BW'($urandom);
    bus.Complete     = rbit();
    if (n == 0) pushExp(s + 3, EV_DONE, 0, 1'b1);
    for (int b = 0; b < n; b++) begin
      step();
      df = (df_fix >= 0) ? df_fix : int'($urandom_range(0, 3));
      for (int i = 0; i < df; i++) begin
        bus.FIFO_ok  = 1'b0;
        bus.Complete = rbit();
        bus.NewData  = rbit();
        step();
      end
      bus.FIFO_ok  = 1'b1;
      bus.Complete = rbit();
      t = cyc;
      pushExp(t + 2, EV_SEND, n - b, 1'b0);
      if (wr) pushExp(t + 2, EV_FIFO_RD, n - b, 1'b0);
      step();
      bus.FIFO_ok  = rbit();
      bus.Complete = rbit();
      step();
      w  = cyc;
      dc = (dc_fix >= 0) ? dc_fix : ((dc_fix == -2) ? -1 : int'($urandom_range(0, 6)));
      for (int j = 0; j < 4000; j++) begin
        bus.FIFO_ok = rbit();
        bus.NewData = rbit();
        if (abort_blk == b && j == 1) begin
          rst = 1'b1;
          bus.NewData = 1'b1;
          #1;
          checkResetValues("abort");
          checkOutput("abort_pending_events", 32'(expq.size()), 0);
          step();
          step();
          rst = 1'b0;
          return;
        end
        if (j == dc) begin
          bus.Complete = 1'b1;
          if (!wr) pushExp(w + j + 1, EV_FIFO_WR, n - b - 1, 1'b0);
          if (b == n - 1) pushExp(w + j + 2, EV_DONE, 0, 1'b1);
          break;
        end
        bus.Complete = 1'b0;
        if (ten && treg != 0 && j == treg) begin
          pushExp(w + j + 1, EV_TIMEOUT, 0, 1'b1);
          timed_out = 1'b1;
          break;
        end
        if (j == 3999) checkOutput("wait_bound", 0, 1);
        step();
      end
      if (timed_out) break;
    end
    step();
    bus.Complete = 1'b0;
    bus.FIFO_ok  = 1'b0;
    bus.NewData  = hold_nd;
    if (!timed_out) step();
    if (hold_nd) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput("rearm_hold_idle", 32'(bus.Idle), 1);
        step();
      end
    end
    bus.NewData = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.NewData = 1'b0; bus.WriteRead = 1'b0; bus.Blocks = '0;
    bus.MultipleData = 1'b0; bus.Timeout_enable = 1'b0; bus.Timeout_reg = '0;
    bus.FIFO_ok = 1'b0; bus.Complete = 1'b0;
    rst = 1'b1;
    step(); step(); step();
    checkResetValues("reset");
    rst = 1'b0;
    step();

    $display("[TB] directed: single write block");
    applyStimulus(1'b1, 1, 1'b0, 1'b0, 0, 3, 10, -1, 1'b0);
    $display("[TB] directed: three-block read");
    applyStimulus(1'b0, 3, 1'b1, 1'b0, 0, -1, -1, -1, 1'b0);
    $display("[TB] directed: timeout abort");
    applyStimulus(1'b1, 2, 1'b1, 1'b1, 70, -1, -2, -1, 1'b0);
    checkOutput("after_timeout_idle", 32'(bus.Idle), 1);
    checkOutput("after_timeout_left", 32'(bus.Blocks_left), 0);
    $display("[TB] directed: completion on timeout match");
    applyStimulus(1'b0, 1, 1'b0, 1'b1, 70, -1, 70, -1, 1'b0);
    $display("[TB] directed: zero blocks");
    applyStimulus(1'b1, 0, 1'b1, 1'b0, 0, -1, -1, -1, 1'b0);
    $display("[TB] directed: zero limit disables timeout");
    applyStimulus(1'b0, 1, 1'b0, 1'b1, 0, -1, 20, -1, 1'b0);
    $display("[TB] directed: held NewData does not re-arm");
    applyStimulus(1'b1, 2, 1'b1, 1'b0, 0, -1, -1, -1, 1'b1);
    $display("[TB] directed: reset during block 2 of 4");
    applyStimulus(1'b0, 4, 1'b1, 1'b0, 0, -1, 5, 1, 1'b0);
    applyStimulus(1'b0, 4, 1'b1, 1'b0, 0, -1, -1, -1, 1'b0);

    $display("[TB] random operations");
    for (int r = 0; r < 30; r++) begin
      bit ten, never;
      int treg;
      ten   = rbit();
      treg  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 8));
      never = ten && (treg != 0) && ($urandom_range(0, 3) == 0);
      applyStimulus(rbit(), int'($urandom_range(0, 4)), rbit(), ten, treg,
                    -1, never ? -2 : -1, -1, ($urandom_range(0, 3) == 0));
    end

    step(); step();
    checkOutput("leftover_events", 32'(expq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
